// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage. Owns the fetch PC, presents the word address to a
//   combinational instruction memory and captures the returned word into the
//   IF/ID pipeline register. Supports hazard stall, branch redirect (which
//   flushes IF/ID) and halts once the last instruction-memory word is fetched.
//
// Ports
//   clk            in   1   rising-edge clock
//   rst            in   1   asynchronous reset, active-low
//   imem_addr      out  6   instruction-memory word address (pc[7:2])
//   imem_data      in   32  instruction word, combinational in imem_addr
//   stall          in   1   hold PC and IF/ID
//   branch_taken   in   1   redirect request
//   branch_target  in   32  redirect byte address (bits [1:0] ignored)
//   pc             out  32  current fetch PC
//   if_id_pc       out  32  PC of the instruction held in IF/ID
//   if_id_inst     out  32  instruction held in IF/ID
//   if_id_valid    out  1   1 = real instruction, 0 = bubble
//   halted         out  1   1 = fetch halted at end of memory
// ----------------------------------------------------------------------------
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0004,
   parameter int unsigned IMEM_DEPTH = 64,
   parameter logic [31:0] NOP_INST   = 32'h0000_0033
) (
   input  logic        clk,
   input  logic        rst,
   output logic [5:0]  imem_addr,
   input  logic [31:0] imem_data,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] pc,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_inst,
   output logic        if_id_valid,
   output logic        halted
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   localparam logic [5:0] LAST_WORD = 6'(IMEM_DEPTH - 1);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_inst_q, id_inst_d;
   logic        id_valid_q, id_valid_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_PC;
         id_pc_q    <= '0;
         id_inst_q  <= NOP_INST;
         id_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         id_pc_q    <= id_pc_d;
         id_inst_q  <= id_inst_d;
         id_valid_q <= id_valid_d;
      end
   end

   // Priority: redirect > stall > halt check > advance.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;
      id_valid_d = id_valid_q;

      if (branch_taken) begin
         // Redirect from either state; the word in IF/ID is on the wrong path.
         state_d    = ST_RUN;
         pc_d       = {branch_target[31:2], 2'b00};
         id_pc_d    = '0;
         id_inst_d  = NOP_INST;
         id_valid_d = 1'b0;
      end else if (state_q == ST_HALT) begin
         // PC parked; feed bubbles unless decode is stalled.
         if (!stall) begin
            id_pc_d    = '0;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
         end
      end else if (!stall) begin
         id_pc_d    = pc_q;
         id_inst_d  = imem_data;
         id_valid_d = 1'b1;
         if (pc_q[7:2] == LAST_WORD) begin
            state_d = ST_HALT;
         end else begin
            pc_d = pc_q + 32'd4;
         end
      end
   end

   assign imem_addr   = pc_q[7:2];
   assign pc          = pc_q;
   assign if_id_pc    = id_pc_q;
   assign if_id_inst  = id_inst_q;
   assign if_id_valid = id_valid_q;
   assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

   logic        clk;
   logic        rst;
   logic [5:0]  imem_addr;
   logic [31:0] imem_data;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] pc;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_inst;
   logic        if_id_valid;
   logic        halted;

   int unsigned n_checks;
   int unsigned n_errors;

   localparam logic [31:0] NOP = 32'h0000_0033;

   if_fetch_stage #(
      .RESET_PC  (32'h0000_0004),
      .IMEM_DEPTH(64),
      .NOP_INST  (32'h0000_0033)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_addr    (imem_addr),
      .imem_data    (imem_data),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .pc           (pc),
      .if_id_pc     (if_id_pc),
      .if_id_inst   (if_id_inst),
      .if_id_valid  (if_id_valid),
      .halted       (halted)
   );

   // Memory image: word i holds 0xA500_0000 + i, recognisable per address.
   function automatic logic [31:0] mem(input int unsigned i);
      return 32'hA500_0000 + 32'(i);
   endfunction

   assign imem_data = mem(int'(imem_addr));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_idpc,
                            input logic [31:0] e_inst, input logic e_valid, input logic e_halt);
      check({tag, ".pc"},    pc,                  e_pc);
      check({tag, ".idpc"},  if_id_pc,            e_idpc);
      check({tag, ".inst"},  if_id_inst,          e_inst);
      check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
      check({tag, ".halt"},  {31'd0, halted},      {31'd0, e_halt});
   endtask

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      rst           = 1'b0;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = '0;

      step();
      step();
      check_all("reset", 32'h4, 32'h0, NOP, 1'b0, 1'b0);
      check("reset.addr", {26'd0, imem_addr}, 32'd1);
      @(negedge clk);
      rst = 1'b1;

      // Straight-line fetch
      step();
      check_all("fetch1", 32'h8, 32'h4, mem(1), 1'b1, 1'b0);
      step();
      step();
      check_all("fetch3", 32'h10, 32'hC, mem(3), 1'b1, 1'b0);

      // Stall two cycles
      stall = 1'b1;
      step();
      check_all("stall1", 32'h10, 32'hC, mem(3), 1'b1, 1'b0);
      step();
      check_all("stall2", 32'h10, 32'hC, mem(3), 1'b1, 1'b0);

      // Redirect beats stall; low target bits dropped
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0027;
      step();
      check_all("redir", 32'h24, 32'h0, NOP, 1'b0, 1'b0);
      branch_taken = 1'b0;
      stall        = 1'b0;
      step();
      check_all("after_redir", 32'h28, 32'h24, mem(9), 1'b1, 1'b0);

      // Run to end of memory
      branch_taken  = 1'b1;
      branch_target = 32'h0000_00F4;
      step();
      branch_taken = 1'b0;
      check_all("to_f4", 32'hF4, 32'h0, NOP, 1'b0, 1'b0);
      step();
      step();
      check_all("at_fc", 32'hFC, 32'hF8, mem(62), 1'b1, 1'b0);
      step();
      check_all("halt", 32'hFC, 32'hFC, mem(63), 1'b1, 1'b1);

      // Stall while halted holds IF/ID; release inserts bubbles
      stall = 1'b1;
      step();
      check_all("halt_stall", 32'hFC, 32'hFC, mem(63), 1'b1, 1'b1);
      stall = 1'b0;
      step();
      check_all("halt_bub1", 32'hFC, 32'h0, NOP, 1'b0, 1'b1);
      step();
      check_all("halt_bub2", 32'hFC, 32'h0, NOP, 1'b0, 1'b1);

      // Redirect out of HALT
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0020;
      step();
      branch_taken = 1'b0;
      check_all("unhalt", 32'h20, 32'h0, NOP, 1'b0, 1'b0);
      step();
      check_all("unhalt_run", 32'h24, 32'h20, mem(8), 1'b1, 1'b0);

      // Upper PC bits ignored for addressing
      branch_taken  = 1'b1;
      branch_target = 32'h1000_0009;
      step();
      branch_taken = 1'b0;
      check("hi.pc", pc, 32'h1000_0008);
      check("hi.addr", {26'd0, imem_addr}, 32'd2);
      step();
      check_all("hi_run", 32'h1000_000C, 32'h1000_0008, mem(2), 1'b1, 1'b0);

      // Async reset mid-cycle at pc=0x20
      branch_taken  = 1'b1;
      branch_target = 32'h0000_001C;
      step();
      branch_taken = 1'b0;
      step();
      check_all("pre_rst", 32'h20, 32'h1C, mem(7), 1'b1, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      check_all("async_rst", 32'h4, 32'h0, NOP, 1'b0, 1'b0);
      #3;
      rst = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
